// File: rtl/wddl_addkey_sequencer.sv
// WDDL AddRoundKey word sequencer. It precharges the rails, drives the operands
// dual-rail into the XOR word stage, captures the result and returns it single-rail.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high, rails precharged
// PRE   | precharge phase, all rails 0 for PRE_CYCLES cycles
// EVAL  | rails complementary from the registered operands for EVAL_CYCLES cycles
// DONE  | result held on out_*, rails precharged, waiting for out_ready
module wddl_addkey_sequencer #(
   parameter int WORD        = 32,
   parameter int PRE_CYCLES  = 1,
   parameter int EVAL_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [WORD-1:0] state_in,
   input  logic [WORD-1:0] key_in,
   output logic [WORD-1:0] In1_T,
   output logic [WORD-1:0] In1_F,
   output logic [WORD-1:0] In2_T,
   output logic [WORD-1:0] In2_F,
   input  logic [WORD-1:0] Res_T,
   input  logic [WORD-1:0] Res_F,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [WORD-1:0] out_data,
   output logic            rail_err,
   output logic [WORD-1:0] err_mask
);

   localparam int MAX_CYCLES = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES) + 1;
   localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYCLES - 1);
   localparam logic [CW-1:0] EVAL_LAST = CW'(EVAL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      EVAL = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            accept;
   logic            capture;
   logic            rails_on_nxt;
   logic [WORD-1:0] op_state;
   logic [WORD-1:0] op_key;
   logic [WORD-1:0] err_mask_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      capture   = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = PRE;
               cnt_nxt   = '0;
            end
         end
         PRE: begin
            if (cnt == PRE_LAST) begin
               state_nxt = EVAL;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         EVAL: begin
            if (cnt == EVAL_LAST) begin
               capture   = 1'b1;
               state_nxt = DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Rails are registered straight from the next state, so every pair moves
   // between (0,0) and a complementary codeword in a single edge.
   assign rails_on_nxt = (state_nxt == EVAL);
   assign err_mask_nxt = ~(Res_T ^ Res_F);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_state <= '0;
         op_key   <= '0;
         In1_T    <= '0;
         In1_F    <= '0;
         In2_T    <= '0;
         In2_F    <= '0;
         out_data <= '0;
         err_mask <= '0;
         rail_err <= 1'b0;
      end else begin
         if (accept) begin
            op_state <= state_in;
            op_key   <= key_in;
         end
         if (capture) begin
            out_data <= Res_T;
            err_mask <= err_mask_nxt;
            rail_err <= |err_mask_nxt;
         end
         In1_T <= rails_on_nxt ? op_state  : '0;
         In1_F <= rails_on_nxt ? ~op_state : '0;
         In2_T <= rails_on_nxt ? op_key    : '0;
         In2_F <= rails_on_nxt ? ~op_key   : '0;
      end
   end

endmodule

// File: doc/wddl_addkey_sequencer.md
Name: wddl_addkey_sequencer

Overview:
- Sequences one WDDL dual-rail XOR word operation (AddRoundKey word) for the AES-256 countermeasure datapath.
- Accepts single-rail state and key words over a valid/ready handshake, then drives them dual-rail into the WDDL XOR word stage directly downstream.
- Enforces a precharge phase (all rails 0) before every evaluation, captures the dual-rail result, and returns it single-rail with a rail-integrity flag.

Parameters:
WORD, 32, word width in bits; must be at least 1.
PRE_CYCLES, 1, precharge cycles before each evaluation; must be at least 1.
EVAL_CYCLES, 2, evaluation cycles rails are held before capture; must be at least 1.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  state/key words valid.
in_ready  output  1  block can accept a new operand pair.
state_in  input  WORD  single-rail state word.
key_in  input  WORD  single-rail round-key word.
In1_T  output  WORD  true rail of state operand to XOR stage.
In1_F  output  WORD  false rail of state operand.
In2_T  output  WORD  true rail of key operand.
In2_F  output  WORD  false rail of key operand.
Res_T  input  WORD  true rail of result from XOR stage.
Res_F  input  WORD  false rail of result from XOR stage.
out_valid  output  1  result word valid.
out_ready  input  1  consumer accepts result.
out_data  output  WORD  single-rail result (captured Res_T).
rail_err  output  1  at least one captured result bit had Res_T == Res_F.
err_mask  output  WORD  per-bit rail error, 1 where Res_T == Res_F at capture.

Behaviour:
- States: IDLE, PRE, EVAL, DONE. Phase counter is clog2(max(PRE_CYCLES,EVAL_CYCLES))+1 bits wide.
- Reset (rst_n low at a rising edge): state IDLE, counter 0. Operand registers, out_data, err_mask and rail_err all 0. All four rail outputs 0, out_valid 0, in_ready 1.
- Reset overrides everything, including mid-PRE, mid-EVAL or mid-DONE. An in-flight operation is discarded with no output.
- IDLE: in_ready=1, rails 0.
  - in_valid=1 at an edge registers state_in and key_in, moves to PRE and clears the counter.
  - in_valid=0 stays in IDLE.
- PRE: in_ready=0, all rails 0 for exactly PRE_CYCLES cycles, then EVAL with the counter cleared.
- EVAL: rails driven from the registered operands: In1_T=state, In1_F=~state, In2_T=key, In2_F=~key. Held for exactly EVAL_CYCLES cycles.
- Capture on the edge ending the last EVAL cycle:
  - out_data <= Res_T.
  - err_mask <= ~(Res_T ^ Res_F).
  - rail_err <= |err_mask.
  - Next state DONE.
- DONE: rails return to 0 (precharge) on entry. out_valid=1; out_data, err_mask and rail_err held stable.
  - out_ready=1 at an edge completes the transfer and returns to IDLE with out_valid 0.
  - A new operand cannot be accepted in the same cycle because in_ready=0 in DONE.
  - out_ready=0 holds DONE indefinitely.
- Latency: accept edge t0 → out_valid high after edge t0+PRE_CYCLES+EVAL_CYCLES (t0+3 at defaults).
  - Minimum issue interval is PRE_CYCLES+EVAL_CYCLES+2 cycles with out_ready tied 1.
- Rails are never driven with T=F=1. Each rail pair is either precharge (0,0) or complementary; no cycle sees a direct transition from one valid codeword to another.
- in_valid is ignored outside IDLE. state_in and key_in only need to be stable at the accept edge.
- Rail errors do not alter sequencing; the flagged result is still delivered.

Test Plan:
- Reset, then state_in=0x00112233, key_in=0xFFFFFFFF with in_valid=1 for one cycle, ideal WDDL XOR model, out_ready=1 → out_valid exactly 3 cycles after accept, out_data=0xFFEEDDCC, rail_err=0, err_mask=0.
- Monitor rails across the previous transaction → all rails 0 during IDLE/PRE/DONE; during EVAL In1_T=0x00112233, In1_F=0xFFEEDDCC, In2_T=0xFFFFFFFF, In2_F=0x00000000; never T=F=1.
- Fault injection: force Res_F[0]=Res_T[0] with operands 0xA5A5A5A5 and 0x5A5A5A5A → out_data=0xFFFFFFFF, err_mask=0x00000001, rail_err=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid, in_valid held 1 with a second pair → out_valid, out_data and in_ready=0 stable. Release → second pair accepted on the cycle after the transfer, and its result is delivered correctly.
- Reset mid-EVAL: assert rst_n=0 for one edge during EVAL → next cycle IDLE, rails 0, out_valid 0, in_ready 1; no stale result appears afterwards.
- Parameter sweep PRE_CYCLES=3, EVAL_CYCLES=1, WORD=8: operands 0x3C and 0x0F → out_valid 4 cycles after accept, out_data=0x33; rails precharged for exactly 3 cycles.
